sync_monitor: RTL and testbench

- Receives a periodic square-wave sync signal, either our own syncout or a neighbouring board's.
- Each toggle of the signal is an event. Nominally there are FREQ_CLK clk cycles between toggles.
- Resynchronises the input, detects both edges, measures the interval between edges, and declares lock or loss of lock.
- Output feeds acquisition timestamping and a status LED.

---
 rtl/sync_monitor.sv | 169 ++++++++++++++++
 tb/tb_sync_monitor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sync_monitor.sv
// Sync input monitor: resynchronise, detect edges, measure edge-to-edge interval, track lock.
// Optional deglitch filter enabled by defining SYNC_MON_GLITCH_EN (adds parameter GLITCH_CYC).
module sync_monitor #(
   parameter int FREQ_CLK   = 50000000,
   parameter int TOL        = 1000,
   parameter int LOCK_COUNT = 3,
   parameter int CNT_W      = 32
`ifdef SYNC_MON_GLITCH_EN
   ,
   parameter int GLITCH_CYC = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sync_in,
   output logic             edge_pulse,
   output logic [15:0]      edge_count,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic [7:0]       error_count
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FREQ_CLK + TOL + 1);
   localparam logic [CNT_W-1:0] LO    = CNT_W'(FREQ_CLK - TOL);
   localparam logic [CNT_W-1:0] HI    = CNT_W'(FREQ_CLK + TOL);
   localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t           state, state_next;
   logic [GW-1:0]    good, good_next;
   logic             s1, s2, lvl, prev, evt;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic             in_tol, at_limit, pv, bad, to;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= sync_in;
         s2   <= s1;
         prev <= lvl;
      end
   end

`ifdef SYNC_MON_GLITCH_EN
   localparam int GCW = $clog2(GLITCH_CYC + 1);
   logic           filt;
   logic [GCW-1:0] gcnt;

   // Level only follows s2 after it has disagreed for GLITCH_CYC straight cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt <= 1'b0;
         gcnt <= '0;
      end else if (s2 == filt) begin
         gcnt <= '0;
      end else if (gcnt == GCW'(GLITCH_CYC - 1)) begin
         filt <= s2;
         gcnt <= '0;
      end else begin
         gcnt <= gcnt + 1'b1;
      end
   end
   assign lvl = filt;
`else
   assign lvl = s2;
`endif

   assign evt      = lvl ^ prev;
   // cnt is 0 in the edge_pulse cycle, so the interval ending at this edge is cnt+1.
   assign cnt_inc  = cnt + 1'b1;
   assign in_tol   = (cnt_inc >= LO) && (cnt_inc <= HI);
   assign at_limit = (cnt_inc == LIMIT);
   assign locked   = (state == LOCKED);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         good  <= '0;
      end else begin
         state <= state_next;
         good  <= good_next;
      end
   end

   always_comb begin
      state_next = state;
      good_next  = good;
      pv         = 1'b0;
      bad        = 1'b0;
      to         = 1'b0;
      case (state)
         IDLE: begin
            if (evt) begin
               state_next = ACQUIRE;
               good_next  = '0;
            end
         end
         ACQUIRE: begin
            if (evt) begin
               pv = 1'b1;
               if (!in_tol) begin
                  bad       = 1'b1;
                  good_next = '0;
               end else if (good == GW'(LOCK_COUNT - 1)) begin
                  state_next = LOCKED;
                  good_next  = '0;
               end else begin
                  good_next = good + 1'b1;
               end
            end else if (at_limit) begin
               to         = 1'b1;
               state_next = IDLE;
               good_next  = '0;
            end
         end
         LOCKED: begin
            if (evt) begin
               pv = 1'b1;
               if (!in_tol) begin
                  bad        = 1'b1;
                  good_next  = '0;
                  state_next = ACQUIRE;
               end
            end else if (at_limit) begin
               to         = 1'b1;
               state_next = IDLE;
               good_next  = '0;
            end
         end
         default: begin
            state_next = IDLE;
            good_next  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         edge_pulse   <= 1'b0;
         edge_count   <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         error_count  <= '0;
      end else begin
         edge_pulse   <= evt;
         period_valid <= pv;
         timeout      <= to;
         if (evt)
            edge_count <= edge_count + 16'd1;
         if (pv)
            period <= cnt_inc;
         if ((bad || to) && (error_count != 8'hFF))
            error_count <= error_count + 8'd1;
         if (evt)
            cnt <= '0;
         else if (cnt != LIMIT)
            cnt <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_sync_monitor.sv
// Bench for sync_monitor: toggle-gap vector table drives sync_in, scoreboard checks each edge_pulse.
module tb_sync_monitor;
   localparam int F = 100, T = 2, L = 3, W = 16;
`ifdef SYNC_MON_GLITCH_EN
   localparam int G = 4;
   localparam int LAT = 3 + G;
`else
   localparam int LAT = 3;
`endif

   logic         clk = 1'b0, reset = 1'b1, sync_in = 1'b0;
   logic         edge_pulse, period_valid, locked, timeout;
   logic [15:0]  edge_count;
   logic [W-1:0] period;
   logic [7:0]   error_count;

   always #5 clk = ~clk;

   sync_monitor #(
      .FREQ_CLK(F), .TOL(T), .LOCK_COUNT(L), .CNT_W(W)
`ifdef SYNC_MON_GLITCH_EN
      , .GLITCH_CYC(G)
`endif
   ) dut (
      .clk(clk), .reset(reset), .sync_in(sync_in),
      .edge_pulse(edge_pulse), .edge_count(edge_count), .period(period),
      .period_valid(period_valid), .locked(locked), .timeout(timeout),
      .error_count(error_count)
   );

   typedef struct {int gap; bit pv; int per; bit lk; int err; int ec;} vec_t;
   typedef struct {int cyc; bit pv; int per; bit lk; int err; int ec;} exp_t;

   vec_t tbl[18];
   exp_t sb[$];
   int   checks = 0, errors = 0, cyc = 0, last_edge = 0, n_to = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard consumer: every edge_pulse pops one expected record.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            check("pv_needs_edge", period_valid & ~edge_pulse, 0);
            if (edge_pulse) begin
               last_edge = cyc;
               check("edge_expected", sb.size() > 0, 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("latency", cyc, e.cyc);
                  check("period_valid", period_valid, e.pv);
                  if (e.pv) check("period", period, e.per);
                  check("locked", locked, e.lk);
                  check("error_count", error_count, e.err);
                  check("edge_count", edge_count, e.ec);
               end
            end
            if (timeout) begin
               n_to++;
               check("timeout_gap", cyc - last_edge, F + T + 1);
               check("timeout_locked", locked, 0);
            end
         end
      end
   end

   task automatic run(input int a, input int b);
      for (int i = a; i < b; i++) begin
         repeat (tbl[i].gap) @(posedge clk);
         #1;
         sync_in = ~sync_in;
         sb.push_back('{cyc + LAT, tbl[i].pv, tbl[i].per, tbl[i].lk, tbl[i].err, tbl[i].ec});
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      //             gap  pv per lk err ec
      tbl[0]  = '{   5, 0,   0, 0, 0,  1};
      tbl[1]  = '{ 100, 1, 100, 0, 0,  2};
      tbl[2]  = '{ 100, 1, 100, 0, 0,  3};
      tbl[3]  = '{ 100, 1, 100, 1, 0,  4};
      tbl[4]  = '{ 103, 1, 103, 0, 1,  5};
      tbl[5]  = '{ 100, 1, 100, 0, 1,  6};
      tbl[6]  = '{  98, 1,  98, 0, 1,  7};
      tbl[7]  = '{ 100, 1, 100, 1, 1,  8};
      tbl[8]  = '{ 102, 1, 102, 1, 1,  9};
      tbl[9]  = '{  10, 0,   0, 0, 2, 10};
      tbl[10] = '{ 100, 1, 100, 0, 2, 11};
      tbl[11] = '{ 100, 1, 100, 0, 2, 12};
      tbl[12] = '{ 100, 1, 100, 1, 2, 13};
      tbl[13] = '{ 100, 1, 100, 0, 0,  2};
      tbl[14] = '{ 100, 0,   0, 0, 1,  3};
      tbl[15] = '{ 100, 1, 100, 0, 1,  4};
      tbl[16] = '{ 100, 1, 100, 0, 1,  5};
      tbl[17] = '{ 100, 1, 100, 1, 1,  6};

      // Reset held while sync_in toggles: all outputs stay 0.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         sync_in = ~sync_in;
         @(negedge clk);
         check("reset_outputs", {edge_pulse, edge_count, period, period_valid, locked,
                                 timeout, error_count}, 0);
      end
      @(posedge clk); #1;
      sync_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      mon_en = 1'b1;

      // Acquire, lock, bad 103 period, relock via 100/98/100, 102 stays locked.
      run(0, 9);
      drain();

      // Stop toggling: one timeout 103 cycles after the last edge.
      n = 0;
      while (n_to == 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("timeout_seen", n_to, 1);
      repeat (150) @(negedge clk);
      check("timeout_once", n_to, 1);
      check("err_after_timeout", error_count, 2);
      check("locked_after_timeout", locked, 0);
      check("period_hold", period, 102);

      // Reference edge then three good periods relock.
      run(9, 13);
      drain();
      check("pre_reset_locked", locked, 1);

      // Asynchronous reset between clock edges.
      @(posedge clk); #2;
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      check("async_rst_locked", locked, 0);
      check("async_rst_edge_count", edge_count, 0);
      check("async_rst_error_count", error_count, 0);
      check("async_rst_period", period, 0);
      repeat (2) @(posedge clk);
      #1;
      // sync_in is high here, so release itself produces a reference edge.
      reset = 1'b0;
      mon_en = 1'b1;
      sb.push_back('{cyc + LAT, 1'b0, 0, 1'b0, 0, 1});
      run(13, 14);
      drain();

`ifdef SYNC_MON_GLITCH_EN
      // A 2-cycle pulse must be filtered out completely.
      @(posedge clk); #1;
      sync_in = ~sync_in;
      repeat (2) @(posedge clk);
      #1;
      sync_in = ~sync_in;
`endif
      repeat (30) @(negedge clk);
      check("glitch_no_edge", edge_count, 2);

      // Gap forces a timeout; then reference edge and relock.
      run(14, 18);
      drain();
      check("timeouts_total", n_to, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
